alu_arbiter: RTL and testbench

//   Shares one combinational ALU(R,F,A,B) between two requesters. Round-robin arbitration,

---
 rtl/alu_arbiter_if.sv | 35 +++
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester-side request/response bundle for alu_arbiter
//
// Purpose: carries both requesters' request and response handshakes as one bundle.
// Signals (packing: requester i in slice i):
//   req_valid  [1:0]        request valid per requester
//   req_ready  [1:0]        request accepted (one-hot or zero)
//   req_a/b    [2*WIDTH-1:0] operands
//   req_f      [2*OPW-1:0]  opcodes
//   rsp_valid  [1:0]        result valid per requester (one-hot or zero)
//   rsp_ready  [1:0]        requester takes result
//   rsp_r      [WIDTH-1:0]  shared result bus
// Modports: master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [2*OPW-1:0]   req_f;
    logic [1:0]         rsp_valid;
    logic [1:0]         rsp_ready;
    logic [WIDTH-1:0]   rsp_r;

    modport master (
        output req_valid, req_a, req_b, req_f, rsp_ready,
        input  req_ready, rsp_valid, rsp_r
    );

    modport slave (
        input  req_valid, req_a, req_b, req_f, rsp_ready,
        output req_ready, rsp_valid, rsp_r
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
//
// Purpose: grants one of two requesters, registers its operands onto the ALU inputs,
// holds them for EXEC_CYCLES cycles, captures the ALU result and returns it to the
// granted requester with a valid/ready handshake.
// Optional feature macro: ALU_ARB_ZERO_FLAG_EN adds output rsp_zero (result == 0).
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   bus        slave modport of alu_arbiter_if (request/response handshakes)
//   alu_a/b/f  out  registered operands/opcode to the ALU
//   alu_r      in   ALU result
//   busy       out  high while an operation is in EXEC or RESP
//   rsp_zero   out  (ALU_ARB_ZERO_FLAG_EN only) captured result was zero
module alu_arbiter #(
    parameter int WIDTH       = 32,
    parameter int OPW         = 3,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    alu_arbiter_if.slave     bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_f,
    input  logic [WIDTH-1:0] alu_r,
    output logic             busy
`ifdef ALU_ARB_ZERO_FLAG_EN
    ,
    output logic             rsp_zero
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t           state;
    logic             rr_ptr;
    logic             owner;
    logic [3:0]       cnt;
    logic             grant;
    logic             accept;
    logic [1:0]       rsp_valid_q;
    logic [WIDTH-1:0] rsp_r_q;

    // A lone requester wins outright; rr_ptr only breaks ties.
    always_comb begin
        grant = rr_ptr;
        if (bus.req_valid == 2'b01) begin
            grant = 1'b0;
        end else if (bus.req_valid == 2'b10) begin
            grant = 1'b1;
        end
    end

    assign accept        = (state == IDLE) && (bus.req_valid != 2'b00);
    assign bus.req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_r     = rsp_r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            owner       <= 1'b0;
            cnt         <= 4'd0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_f       <= '0;
            rsp_r_q     <= '0;
            rsp_valid_q <= 2'b00;
            busy        <= 1'b0;
`ifdef ALU_ARB_ZERO_FLAG_EN
            rsp_zero    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a <= grant ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
                        alu_b <= grant ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
                        alu_f <= grant ? bus.req_f[2*OPW-1:OPW]     : bus.req_f[OPW-1:0];
                        owner <= grant;
                        cnt   <= CNT_INIT;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands stay put; R is sampled only after EXEC_CYCLES cycles of settling.
                    if (cnt == 4'd0) begin
                        rsp_r_q     <= alu_r;
                        rsp_valid_q <= owner ? 2'b10 : 2'b01;
`ifdef ALU_ARB_ZERO_FLAG_EN
                        rsp_zero    <= (alu_r == '0);
`endif
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    // Only the owner's rsp_ready completes the response.
                    if (bus.rsp_ready[owner]) begin
                        rsp_valid_q <= 2'b00;
                        busy        <= 1'b0;
                        rr_ptr      <= ~owner;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;
    localparam int W  = 32;
    localparam int OW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(W), .OPW(OW)) bus ();
    alu_arbiter_if #(.WIDTH(W), .OPW(OW)) bus4 ();

    logic [W-1:0]  alu_a, alu_b, alu_r, alu_a4, alu_b4, alu_r4;
    logic [OW-1:0] alu_f, alu_f4;
    logic          busy, busy4;
`ifdef ALU_ARB_ZERO_FLAG_EN
    logic          rsp_zero, rsp_zero4;
`endif

    // ALU stub: R = A + B + F mod 2^W
    assign alu_r  = alu_a + alu_b + W'(alu_f);
    assign alu_r4 = alu_a4 + alu_b4 + W'(alu_f4);

    alu_arbiter #(.WIDTH(W), .OPW(OW), .EXEC_CYCLES(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus.slave),
        .alu_a (alu_a),
        .alu_b (alu_b),
        .alu_f (alu_f),
        .alu_r (alu_r),
        .busy  (busy)
`ifdef ALU_ARB_ZERO_FLAG_EN
        ,
        .rsp_zero (rsp_zero)
`endif
    );

    alu_arbiter #(.WIDTH(W), .OPW(OW), .EXEC_CYCLES(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus4.slave),
        .alu_a (alu_a4),
        .alu_b (alu_b4),
        .alu_f (alu_f4),
        .alu_r (alu_r4),
        .busy  (busy4)
`ifdef ALU_ARB_ZERO_FLAG_EN
        ,
        .rsp_zero (rsp_zero4)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected {owner, result} pushed at accept, popped at response handshake.
    typedef struct {
        logic         owner;
        logic [W-1:0] r;
    } sb_t;
    sb_t  sb_q[$];
    logic m_rr;

    always @(negedge clk) begin
        logic   exp_g;
        sb_t    e;
        if (rst) begin
            sb_q.delete();
            m_rr = 1'b0;
        end else begin
            if (bus.req_ready != 2'b00) begin
                exp_g = (bus.req_valid == 2'b11) ? m_rr : (bus.req_valid[0] ? 1'b0 : 1'b1);
                check("sb_grant", 64'(bus.req_ready), exp_g ? 64'd2 : 64'd1);
                e.owner = exp_g;
                if (exp_g)
                    e.r = bus.req_a[2*W-1:W] + bus.req_b[2*W-1:W] + W'(bus.req_f[2*OW-1:OW]);
                else
                    e.r = bus.req_a[W-1:0] + bus.req_b[W-1:0] + W'(bus.req_f[OW-1:0]);
                sb_q.push_back(e);
            end
            if ((bus.rsp_valid & bus.rsp_ready) != 2'b00) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_rsp_owner", 64'(bus.rsp_valid), e.owner ? 64'd2 : 64'd1);
                    check("sb_rsp_r", 64'(bus.rsp_r), 64'(e.r));
                    m_rr = ~e.owner;
                end
            end
        end
    end

    typedef struct {
        logic          who;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [OW-1:0] f;
        logic [W-1:0]  r;
        logic          z;
    } vec_t;
    vec_t vecs[8];

    task automatic set_req(input logic who, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [OW-1:0] f);
        if (who) begin
            bus.req_a[2*W-1:W]   = a;
            bus.req_b[2*W-1:W]   = b;
            bus.req_f[2*OW-1:OW] = f;
        end else begin
            bus.req_a[W-1:0]  = a;
            bus.req_b[W-1:0]  = b;
            bus.req_f[OW-1:0] = f;
        end
    endtask

    task automatic do_op(input vec_t v);
        @(posedge clk); #1;
        set_req(v.who, v.a, v.b, v.f);
        bus.req_valid = v.who ? 2'b10 : 2'b01;
        @(negedge clk);
        check("op_req_ready", 64'(bus.req_ready), v.who ? 64'd2 : 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("op_exec_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("op_exec_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("op_rsp_valid", 64'(bus.rsp_valid), v.who ? 64'd2 : 64'd1);
        check("op_rsp_r", 64'(bus.rsp_r), 64'(v.r));
`ifdef ALU_ARB_ZERO_FLAG_EN
        check("op_rsp_zero", 64'(rsp_zero), 64'(v.z));
`endif
        @(negedge clk);
        check("op_idle_busy", 64'(busy), 64'd0);
        check("op_idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while ((sb_q.size() != 0 || busy) && w < 20) begin
            @(negedge clk);
            w++;
        end
        check(name, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        vecs[0] = '{1'b0, 32'd5,        32'd7,        3'd2, 32'd14,       1'b0};
        vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 3'd0, 32'h00000000, 1'b1};
        vecs[2] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd7, 32'h00000005, 1'b0};
        vecs[3] = '{1'b1, 32'h00000000, 32'h00000000, 3'd0, 32'h00000000, 1'b1};
        vecs[4] = '{1'b1, 32'h12345678, 32'h11111111, 3'd3, 32'h2345678C, 1'b0};
        vecs[5] = '{1'b0, 32'h80000000, 32'h80000000, 3'd1, 32'h00000001, 1'b0};
        vecs[6] = '{1'b0, 32'hDEADBEEF, 32'h00000000, 3'd4, 32'hDEADBEF3, 1'b0};
        vecs[7] = '{1'b1, 32'hAAAAAAAA, 32'h55555555, 3'd5, 32'h00000004, 1'b0};

        rst = 1'b1;
        bus.req_valid  = 2'b00;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_f      = '0;
        bus.rsp_ready  = 2'b11;
        bus4.req_valid = 2'b00;
        bus4.req_a     = '0;
        bus4.req_b     = '0;
        bus4.req_f     = '0;
        bus4.rsp_ready = 2'b11;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_r", 64'(bus.rsp_r), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_alu_b", 64'(alu_b), 64'd0);
        check("rst_alu_f", 64'(alu_f), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // T1/T4 and lone-requester back-to-back grants
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i]);
        end

        // T2 contention from reset
        pulse_reset();
        @(posedge clk); #1;
        set_req(1'b0, 32'd1, 32'd1, 3'd0);
        set_req(1'b1, 32'd2, 32'd2, 3'd1);
        bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (bus.req_ready == 2'b00 && w < 10);
            check("t2_grant", 64'(bus.req_ready), (k % 2 == 1) ? 64'd2 : 64'd1);
        end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        drain("t2_drain");

        // T3 backpressure
        @(posedge clk); #1;
        bus.rsp_ready = 2'b00;
        set_req(1'b0, 32'd9, 32'd1, 3'd0);
        set_req(1'b1, 32'd20, 32'd3, 3'd2);
        bus.req_valid = 2'b01;
        @(negedge clk);
        check("t3_accept", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 2'b11;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 64'(bus.rsp_valid), 64'd1);
            check("t3_hold_r", 64'(bus.rsp_r), 64'd10);
            check("t3_hold_ready", 64'(bus.req_ready), 64'd0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 2'b10;
        @(negedge clk);
        check("t3_nonowner_ignored", 64'(bus.rsp_valid), 64'd1);
        @(posedge clk); #1;
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        @(negedge clk);
        check("t3_fair_next", 64'(bus.req_ready), 64'd2);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        drain("t3_drain");

        // T5 reset mid-op: one completed op for 0 leaves rr_ptr=1 first
        do_op(vecs[0]);
        @(posedge clk); #1;
        set_req(1'b0, 32'd4, 32'd4, 3'd0);
        bus.req_valid = 2'b01;
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5e_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("t5e_busy", 64'(busy), 64'd0);
        check("t5e_alu_a", 64'(alu_a), 64'd0);
        check("t5e_alu_b", 64'(alu_b), 64'd0);
        check("t5e_alu_f", 64'(alu_f), 64'd0);
        check("t5e_rsp_r", 64'(bus.rsp_r), 64'd0);
        check("t5e_req_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        check("t5e_no_rsp", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk); #1;
        bus.rsp_ready = 2'b00;
        bus.req_valid = 2'b01;
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5r_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("t5r_rsp_r", 64'(bus.rsp_r), 64'd0);
        check("t5r_busy", 64'(busy), 64'd0);
        check("t5r_alu_a", 64'(alu_a), 64'd0);
        bus.rsp_ready = 2'b11;
        @(posedge clk); #1;
        set_req(1'b1, 32'd6, 32'd6, 3'd6);
        bus.req_valid = 2'b11;
        @(negedge clk);
        check("t5_rr_reset", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        drain("t5_drain");

        // T6 EXEC_CYCLES=4 instance
        @(posedge clk); #1;
        bus4.req_a = {32'd0, 32'd3};
        bus4.req_b = {32'd0, 32'd4};
        bus4.req_f = {3'd0, 3'd1};
        bus4.req_valid = 2'b01;
        @(negedge clk);
        check("t6_accept", 64'(bus4.req_ready), 64'd1);
        @(posedge clk); #1;
        bus4.req_valid = 2'b00;
        bus4.req_a = '1;
        bus4.req_b = '1;
        bus4.req_f = '1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("t6_alu_a", 64'(alu_a4), 64'd3);
            check("t6_alu_b", 64'(alu_b4), 64'd4);
            check("t6_alu_f", 64'(alu_f4), 64'd1);
            check("t6_no_rsp", 64'(bus4.rsp_valid), 64'd0);
        end
        @(negedge clk);
        check("t6_rsp_valid", 64'(bus4.rsp_valid), 64'd1);
        check("t6_rsp_r", 64'(bus4.rsp_r), 64'd8);
        @(negedge clk);
        check("t6_idle_busy", 64'(busy4), 64'd0);

        check("final_sb_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
